// File: rtl/pwl_stim_seq.sv
// pwl_stim_seq: plays a (value, hold) point table as a DAC code; define PWL_RAMP_EN to interpolate within segments
module pwl_stim_seq #(
  parameter int DW = 12,
  parameter int HW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_value_i,
  input  logic [HW-1:0] wr_hold_i,
  input  logic [AW-1:0] last_idx_i,
  input  logic          loop_i,
  input  logic          start_i,
  input  logic          stop_i,
  output logic [DW-1:0] level_o,
  output logic          busy_o,
  output logic [AW-1:0] seg_idx_o,
  output logic          done_o,
  output logic          wr_err_o
);
  localparam int DEPTH = 2 ** AW;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t        state_q;
  logic [DW-1:0] val_q [DEPTH];
  logic [HW-1:0] hold_q [DEPTH];
  logic [AW-1:0] idx_q, last_q, nidx;
  logic [HW-1:0] cnt_q, h_eff;
  logic [DW-1:0] level_q, hold_lvl;
  logic          loop_q, busy_q, done_q, wr_err_q, expire, at_last;
  always_comb begin
    h_eff   = (hold_q[idx_q] == '0) ? HW'(1) : hold_q[idx_q];
    expire  = cnt_q == h_eff - 1'b1;
    at_last = idx_q == last_q;
    nidx    = at_last ? '0 : idx_q + 1'b1;
  end
`ifdef PWL_RAMP_EN
  localparam int PW = DW + HW + 1;
  logic signed [PW-1:0] vi_s, vn_s, k_s, h_s, sum_s;
  // next-cycle level is the ramp evaluated one step further into the segment
  always_comb begin
    vi_s     = $signed({{(PW-DW){1'b0}}, val_q[idx_q]});
    vn_s     = (at_last && !loop_q) ? vi_s : $signed({{(PW-DW){1'b0}}, val_q[nidx]});
    k_s      = $signed({{(PW-HW){1'b0}}, cnt_q + 1'b1});
    h_s      = $signed({{(PW-HW){1'b0}}, h_eff});
    sum_s    = vi_s + ((vn_s - vi_s) * k_s) / h_s;
    hold_lvl = sum_s[DW-1:0];
  end
`else
  assign hold_lvl = level_q;
`endif
  always_ff @(posedge clk) begin
    if (wr_en_i && state_q == IDLE) begin
      val_q[wr_addr_i]  <= wr_value_i;
      hold_q[wr_addr_i] <= wr_hold_i;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      level_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i && !stop_i) begin
          state_q <= PLAY;
          busy_q  <= 1'b1;
          idx_q   <= '0;
          cnt_q   <= '0;
          level_q <= val_q[0];
          last_q  <= last_idx_i;
          loop_q  <= loop_i;
        end
      end else begin
        wr_err_q <= wr_en_i;
        if (stop_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (!expire) begin
          cnt_q   <= cnt_q + 1'b1;
          level_q <= hold_lvl;
        end else if (at_last && !loop_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q   <= nidx;
          cnt_q   <= '0;
          level_q <= val_q[nidx];
        end
      end
    end
  end
  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign seg_idx_o = idx_q;
  assign done_o    = done_q;
  assign wr_err_o  = wr_err_q;
endmodule

// File: tb/tb_pwl_stim_seq.sv
// tb_pwl_stim_seq: randomized scoreboard bench for pwl_stim_seq against a point-list reference model
module tb_pwl_stim_seq;
  localparam int DW = 12, HW = 16, AW = 4, DEPTH = 16;
`ifdef PWL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en_i = 1'b0, loop_i = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0, last_idx_i = '0, seg_idx_o;
  logic [DW-1:0] wr_value_i = '0, level_o;
  logic [HW-1:0] wr_hold_i = '0;
  logic busy_o, done_o, wr_err_o;

  pwl_stim_seq #(.DW(DW), .HW(HW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_value_i(wr_value_i), .wr_hold_i(wr_hold_i), .last_idx_i(last_idx_i),
    .loop_i(loop_i), .start_i(start_i), .stop_i(stop_i), .level_o(level_o),
    .busy_o(busy_o), .seg_idx_o(seg_idx_o), .done_o(done_o), .wr_err_o(wr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {int lv; int idx; int busy; int done;} exp_t;
  exp_t q[$];
  exp_t me;
  int tv[DEPTH], th[DEPTH];
  int total = 0, passed = 0;

  task automatic chk(string n, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (busy_o || done_o)) begin
      if (q.size() == 0) chk("spurious_output", q.size(), 1);
      else begin
        me = q.pop_front();
        chk("level", int'(level_o), me.lv);
        chk("seg_idx", int'(seg_idx_o), me.idx);
        chk("busy", int'(busy_o), me.busy);
        chk("done", int'(done_o), me.done);
      end
    end
  end

  // Expected per-cycle outputs: each point held max(hold,1) cycles, optional ramp toward the next point
  task automatic push_run(int last, bit lp, int n);
    int c, h, vn, lv;
    c = 0;
    while (1) begin
      for (int i = 0; i <= last; i++) begin
        h  = th[i] == 0 ? 1 : th[i];
        vn = i < last ? tv[i+1] : (lp ? tv[0] : tv[i]);
        for (int k = 0; k < h; k++) begin
          if (lp && c == n) return;
          lv = RAMP ? tv[i] + ((vn - tv[i]) * k) / h : tv[i];
          q.push_back('{lv, i, 1, 0});
          c++;
        end
      end
      if (!lp) begin
        q.push_back('{tv[last], last, 0, 1});
        return;
      end
    end
  endtask

  task automatic wr(int a, int v, int h);
    @(negedge clk);
    wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_value_i = DW'(v); wr_hold_i = HW'(h);
    tv[a] = v; th[a] = h;
  endtask

  task automatic play(int last, bit lp, int n, bit collide);
    int len, lastlv, c;
    push_run(last, lp, n);
    len = q.size();
    lastlv = q[$].lv;
    @(negedge clk);
    wr_en_i = 1'b0; last_idx_i = AW'(last); loop_i = lp; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (lp) begin
      repeat (n - 1) @(negedge clk);
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      chk("stop_busy", int'(busy_o), 0);
      chk("stop_level", int'(level_o), lastlv);
      chk("stop_no_done", int'(done_o), 0);
    end else begin
      c = 0;
      while (!done_o && c < 2000) begin
        if (collide && len > 6) begin
          if (c == 1) begin
            wr_en_i = 1'b1; wr_addr_i = AW'($urandom); wr_value_i = DW'($urandom);
            wr_hold_i = HW'($urandom); last_idx_i = AW'($urandom); loop_i = 1'b1;
          end
          if (c == 2) begin
            wr_en_i = 1'b0; start_i = 1'b1;
            chk("wr_err_pulse", int'(wr_err_o), 1);
          end
          if (c == 3) begin
            start_i = 1'b0;
            chk("wr_err_clear", int'(wr_err_o), 0);
          end
        end
        @(negedge clk);
        c++;
      end
      chk("done_seen", int'(done_o), 1);
      chk("done_level", int'(level_o), tv[last]);
      @(negedge clk);
      chk("done_one_cycle", int'(done_o), 0);
      chk("idle_level", int'(level_o), tv[last]);
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #2;
    chk("rst_level", int'(level_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_seg", int'(seg_idx_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_wr_err", int'(wr_err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 100, 2); wr(1, 200, 3); wr(2, 300, 1);
    play(2, 1'b0, 0, 1'b1);
    play(2, 1'b0, 0, 1'b0);
    wr(0, 5, 0); wr(1, 9, 1);
    play(1, 1'b1, 9, 1'b0);
    @(negedge clk);
    wr_en_i = 1'b0; start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    chk("start_stop_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("start_stop_busy2", int'(busy_o), 0);
    wr(0, 100, 2); wr(1, 200, 3); wr(2, 300, 1);
    push_run(2, 1'b1, 3);
    @(negedge clk);
    wr_en_i = 1'b0; last_idx_i = 2; loop_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", int'(level_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_seg", int'(seg_idx_o), 0);
    chk("async_rst_done", int'(done_o), 0);
    chk("async_rst_queue", q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    play(2, 1'b0, 0, 1'b0);
    wr(0, 0, 4); wr(1, 400, 1);
    play(1, 1'b0, 0, 1'b0);
    wr(0, 400, 3); wr(1, 0, 1);
    play(1, 1'b0, 0, 1'b0);
    wr(0, 7, 3);
    play(0, 1'b1, 7, 1'b0);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
      play(int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, int'($urandom_range(3, 40)), 1'b1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pwl_stim_seq.md
Name: pwl_stim_seq

Overview:
- Digital piecewise-linear stimulus sequencer that plays a programmed table of (value, hold) points as a DAC code.
- Sits directly upstream of the analog source mapping (VOLTAGE_SOURCE / BATTERY): `level` sets the source's dc value in mixed-mode gnucap-geda netlists.
- Table is loaded over a simple write port, then played once or looped on `start`.

Parameters:
- DW, 12, width of level/value codes (unsigned)
- HW, 16, width of per-point hold counter
- AW, 4, table address width; DEPTH = 2**AW points

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table index to write
- wr_value  in  DW  point value
- wr_hold  in  HW  point hold length in cycles (0 treated as 1)
- last_idx  in  AW  index of final point played; sampled on accepted start
- loop  in  1  1 = wrap to point 0 after last_idx; sampled on accepted start
- start  in  1  begin playback (single-cycle pulse)
- stop  in  1  abort playback
- level  out  DW  current output code
- busy  out  1  playback active
- seg_idx  out  AW  index of point currently presented
- done  out  1  one-cycle pulse at end of non-loop playback
- wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (async, rst_n=0): level=0, busy=0, seg_idx=0, done=0, wr_err=0, state=IDLE; table contents undefined and not cleared.
- States: IDLE, PLAY. Table is a register array with combinational read.
- IDLE: wr_en writes table[wr_addr] at the clock edge. A start accepted at edge t latches last_idx and loop, enters PLAY; at t+1 level=value[0], seg_idx=0, busy=1.
- PLAY: point i is presented for max(hold[i],1) cycles; the hold counter reloads on each point entry.
  - At hold expiry with i<last_idx: seg_idx=i+1 and level=value[i+1] on the next cycle.
  - At hold expiry with i==last_idx and loop=1: wrap to point 0 with no gap cycle.
  - At hold expiry with i==last_idx and loop=0: go to IDLE; busy=0 and done=1 for one cycle; level keeps value[last_idx].
- stop in PLAY: IDLE next cycle, busy=0, level frozen at current value, no done pulse. stop in IDLE has no effect.
- start while busy: ignored. start and stop in the same IDLE cycle: stop wins, start ignored.
- wr_en while busy: write discarded and wr_err=1 for one cycle; playback unaffected.
- last_idx=0: a single point is played, then done (or that point repeats if loop=1).
- Changes to last_idx or loop during PLAY have no effect until the next start.
- Reset mid-playback: immediate return to reset values; no done pulse.

Optional Feature:
- Macro PWL_RAMP_EN.
- Defined: linear interpolation within each segment. For point i, with H=max(hold[i],1) and k=0..H-1 cycles into the segment, level = v_i + ((v_next - v_i)*k)/H.
  - v_next = value[i+1], or value[0] when wrapping in loop mode.
  - Signed intermediate of DW+HW+1 bits; division truncates toward zero; result is always within [min, max] of v_i and v_next.
  - Final point of a non-loop run is held constant (no ramp).
- Undefined: step output only (level=value[i] for the whole segment); no divider is instantiated.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with level nonzero -> level=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Step playback: load (100,h=2),(200,h=3),(300,h=1), last_idx=2, loop=0, start -> level sequence 100,100,200,200,200,300; done pulses the cycle after the 300; level stays 300.
- Loop and hold=0: load (5,h=0),(9,h=1), last_idx=1, loop=1 -> level 5,9,5,9,... with no gap; done never asserts; stop -> busy=0 next cycle, level frozen.
- Collisions: wr_en during PLAY -> wr_err=1 for one cycle, table unchanged on next run. start+stop in the same IDLE cycle -> busy stays 0. start while busy -> sequence unaffected.
- Mid-play reset: rst_n low during point 1 -> outputs return to reset values; a subsequent start replays from point 0 with the table intact.
- PWL_RAMP_EN: points (0,h=4),(400,h=1), last_idx=1, loop=0 -> level 0,100,200,300,400, then done. Descending segment (400->0, h=3) -> 400,267,134 (truncation toward zero).
